camellia_latency_ctrl: RTL and testbench
========================================

Name: camellia_latency_ctrl

Overview:
- Parametrised block-latency controller for the Camellia core; successor to the fixed 27-cycle ready counter.
- Tracks one in-flight block from data_valid to completion, with a latency chosen per key size.
- Drives the datapath round index and the FL/FL^-1 layer strobe.
- Completion is signalled either as a one-cycle pulse or as a ready held until acknowledged; overrun of an in-flight block is reported.

Parameters:
- LAT_128, 27, cycles from acceptance to out_rdy for 128-bit keys (must be >= 2)
- LAT_256, 35, cycles from acceptance to out_rdy for 192/256-bit keys (must be >= 2)
- COUNT_W, 6, counter and round_idx width; must satisfy 2^COUNT_W > max(LAT_128, LAT_256)
- FL_PERIOD, 6, rounds between FL-layer insertions; requires 3*FL_PERIOD < LAT_256 and 2*FL_PERIOD < LAT_128
- HOLD_RDY, 0, 0 = out_rdy is a one-cycle pulse; 1 = out_rdy holds until out_ack
- RESTART_ON_VALID, 1, 1 = data_valid while busy aborts and reloads; 0 = data_valid while busy is ignored

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- data_valid  in  1  new block present; sampled each rising edge
- key_mode  in  2  0 = 128, 1 = 192, 2 = 256, 3 = reserved (treated as 256); latched only on acceptance
- out_ack  in  1  consumer accepted result; ignored when HOLD_RDY = 0
- busy  out  1  high while in COUNT
- round_idx  out  COUNT_W  elapsed cycles since acceptance; 0 outside COUNT
- fl_en  out  1  FL-layer strobe to datapath
- out_rdy  out  1  result ready
- overrun  out  1  one-cycle pulse when data_valid arrives while a block is pending

Behaviour:
- Reset (rst low, asynchronous): state IDLE, counter 0, latched mode 0; busy, round_idx, fl_en, out_rdy and overrun all 0. Reset mid-count discards the block with no out_rdy.
- States: IDLE, COUNT, DONE. All outputs are registered.
- Acceptance: data_valid = 1 at an edge in IDLE, or under the conditions below.
  - Latch lat = LAT_128 if key_mode == 0, else LAT_256.
  - Latch NFL = 2 for 128-bit keys, 3 otherwise.
  - Go to COUNT with round_idx = 0.
- COUNT: round_idx increments by 1 each edge.
  - At the edge where round_idx == lat-1, go to DONE, set out_rdy = 1 and round_idx = 0.
  - Accepted at edge t0 gives out_rdy high from edge t0+lat.
  - Latency is exact; with lat = 27 the timing matches the legacy counter.
- fl_en is high in COUNT when round_idx == k*FL_PERIOD for k = 1..NFL (defaults: 6 and 12 for 128-bit keys; 6, 12 and 18 otherwise).
- DONE with HOLD_RDY = 0:
  - Next edge goes to IDLE with out_rdy = 0, so out_rdy is high exactly one cycle.
  - data_valid at that edge is accepted and goes straight to COUNT, with no overrun.
- DONE with HOLD_RDY = 1:
  - out_rdy stays high until an edge with out_ack = 1; that edge clears out_rdy and goes to IDLE.
  - data_valid together with out_ack is accepted and goes to COUNT.
  - data_valid without out_ack is ignored and pulses overrun.
- data_valid in COUNT always pulses overrun for one cycle.
  - RESTART_ON_VALID = 1: reload the counter, relatch key_mode, round_idx = 0; the aborted block never raises out_rdy.
  - RESTART_ON_VALID = 0: ignore the new block; the count continues unchanged.
- out_ack outside DONE has no effect.
- The counter never wraps, because the COUNT_W constraint guarantees lat-1 fits.

Test Plan:
- Reset, then data_valid for 1 cycle with key_mode = 0 at edge t0 -> busy high for 27 cycles; fl_en at round_idx 6 and 12 only; out_rdy high only during the cycle after edge t0+27; overrun stays 0.
- key_mode = 2, then key_mode = 3 (defaults) -> out_rdy at t0+35; fl_en at 6, 12 and 18; reserved mode behaves identically to mode 2.
- HOLD_RDY = 1, out_ack withheld 5 cycles after out_rdy, then asserted together with data_valid -> out_rdy high 6 cycles; new count starts the same edge; overrun 0. Repeat with data_valid but no out_ack -> overrun pulse, no new count.
- data_valid at round_idx 10 -> RESTART_ON_VALID = 1: overrun pulse, round_idx back to 0, out_rdy 27 cycles after the second valid only. RESTART_ON_VALID = 0: overrun pulse, out_rdy 27 cycles after the first valid.
- rst asserted at round_idx 15, released 3 cycles later -> all outputs 0 immediately (asynchronous) and stay 0; no out_rdy until a new data_valid.
- Back-to-back: data_valid in the out_rdy pulse cycle (HOLD_RDY = 0) -> accepted; second out_rdy exactly lat cycles later; overrun 0.

Source files
------------

// File: rtl/camellia_latency_ctrl.sv
// Block-latency controller for the Camellia core: tracks one in-flight block,
// drives round index and FL-layer strobe, and reports completion and overrun.
module camellia_latency_ctrl #(
  parameter int LAT_128          = 27,
  parameter int LAT_256          = 35,
  parameter int COUNT_W          = 6,
  parameter int FL_PERIOD        = 6,
  parameter int HOLD_RDY         = 0,
  parameter int RESTART_ON_VALID = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_valid,
  input  logic [1:0]         key_mode,
  input  logic               out_ack,
  output logic               busy,
  output logic [COUNT_W-1:0] round_idx,
  output logic               fl_en,
  output logic               out_rdy,
  output logic               overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [COUNT_W-1:0] LAST_128 = COUNT_W'(LAT_128 - 1);
  localparam logic [COUNT_W-1:0] LAST_256 = COUNT_W'(LAT_256 - 1);
  localparam logic [COUNT_W-1:0] FL_1     = COUNT_W'(FL_PERIOD);
  localparam logic [COUNT_W-1:0] FL_2     = COUNT_W'(2 * FL_PERIOD);
  localparam logic [COUNT_W-1:0] FL_3     = COUNT_W'(3 * FL_PERIOD);

  logic [1:0]         state, state_n;
  logic [COUNT_W-1:0] cnt_n;
  logic [COUNT_W-1:0] last;
  logic               long_r, long_n;
  logic               accept, release_done, ov_n, fl_n;

  // long_r selects both the latency and the third FL insertion.
  assign last = long_r ? LAST_256 : LAST_128;

  always_comb begin
    state_n      = state;
    cnt_n        = round_idx;
    long_n       = long_r;
    accept       = 1'b0;
    ov_n         = 1'b0;
    fl_n         = 1'b0;
    release_done = (HOLD_RDY == 0) || out_ack;
    case (state)
      S_IDLE: accept = data_valid;
      S_COUNT: begin
        ov_n   = data_valid;
        accept = data_valid && (RESTART_ON_VALID != 0);
        if (round_idx == last) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = round_idx + COUNT_W'(1);
        end
      end
      S_DONE: begin
        if (release_done) begin
          state_n = S_IDLE;
          accept  = data_valid;
        end else begin
          ov_n = data_valid;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Acceptance wins over any other transition, including a restart on the last count.
    if (accept) begin
      state_n = S_COUNT;
      cnt_n   = '0;
      long_n  = (key_mode != 2'd0);
    end
    fl_n = (state_n == S_COUNT) &&
           ((cnt_n == FL_1) || (cnt_n == FL_2) || (long_n && (cnt_n == FL_3)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      round_idx <= '0;
      long_r    <= 1'b0;
      busy      <= 1'b0;
      fl_en     <= 1'b0;
      out_rdy   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      round_idx <= cnt_n;
      long_r    <= long_n;
      busy      <= (state_n == S_COUNT);
      fl_en     <= fl_n;
      out_rdy   <= (state_n == S_DONE);
      overrun   <= ov_n;
    end
  end

endmodule

// File: tb/tb_camellia_latency_ctrl.sv
// Bench for camellia_latency_ctrl: three parameter variants share stimulus;
// each scenario compares the selected variant against a timing-based model.
module tb_camellia_latency_ctrl;

  localparam int CW   = 6;
  localparam int FLP  = 6;
  localparam int L128 = 27;
  localparam int L256 = 35;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dv  = 1'b0;
  logic          ack = 1'b0;
  logic [1:0]    km  = 2'd0;
  logic [2:0]    busy_v, fl_v, rdy_v, ov_v;
  logic [CW-1:0] idx_v [3];

  int errors = 0;
  int checks = 0;
  int sel    = 0;

  // Model: a block is described by its acceptance edge and latency only.
  int   edge_n   = 0;
  int   m_t0     = 0;
  int   m_lat    = L128;
  int   m_nfl    = 2;
  logic m_active = 1'b0;
  logic m_ov     = 1'b0;
  logic m_hold   = 1'b0;
  logic m_restart = 1'b1;

  always #5 clk = ~clk;

  // Variant 0: pulse ready, restart. Variant 1: held ready, restart. Variant 2: pulse ready, ignore.
  camellia_latency_ctrl #(.HOLD_RDY(0), .RESTART_ON_VALID(1)) dut_a (
    .clk(clk), .rst(rst), .data_valid(dv), .key_mode(km), .out_ack(ack),
    .busy(busy_v[0]), .round_idx(idx_v[0]), .fl_en(fl_v[0]), .out_rdy(rdy_v[0]), .overrun(ov_v[0]));
  camellia_latency_ctrl #(.HOLD_RDY(1), .RESTART_ON_VALID(1)) dut_b (
    .clk(clk), .rst(rst), .data_valid(dv), .key_mode(km), .out_ack(ack),
    .busy(busy_v[1]), .round_idx(idx_v[1]), .fl_en(fl_v[1]), .out_rdy(rdy_v[1]), .overrun(ov_v[1]));
  camellia_latency_ctrl #(.HOLD_RDY(0), .RESTART_ON_VALID(0)) dut_c (
    .clk(clk), .rst(rst), .data_valid(dv), .key_mode(km), .out_ack(ack),
    .busy(busy_v[2]), .round_idx(idx_v[2]), .fl_en(fl_v[2]), .out_rdy(rdy_v[2]), .overrun(ov_v[2]));

  function automatic logic [CW+3:0] dut_out();
    return {busy_v[sel], idx_v[sel], fl_v[sel], rdy_v[sel], ov_v[sel]};
  endfunction

  function automatic logic [CW+3:0] model_out();
    int e;
    logic b, f, r;
    logic [CW-1:0] ix;
    e  = edge_n - m_t0;
    b  = m_active && (e < m_lat);
    f  = b && (e > 0) && (e % FLP == 0) && (e / FLP <= m_nfl);
    r  = m_active && (m_hold ? (e >= m_lat) : (e == m_lat));
    ix = b ? CW'(e) : '0;
    return {b, ix, f, r, m_ov};
  endfunction

  task automatic model_update(input logic d, input logic [1:0] k, input logic a);
    logic [CW+3:0] pre;
    logic b, r, acc;
    pre = model_out();
    b   = pre[CW+3];
    r   = pre[1];
    edge_n++;
    m_ov = 1'b0;
    acc  = 1'b0;
    if (d) begin
      if (b) begin
        m_ov = 1'b1;
        acc  = m_restart;
      end else if (r && m_hold && !a) begin
        m_ov = 1'b1;
      end else begin
        acc = 1'b1;
      end
    end else if (r && m_hold && a) begin
      m_active = 1'b0;
    end
    if (acc) begin
      m_active = 1'b1;
      m_t0     = edge_n;
      m_lat    = (k == 2'd0) ? L128 : L256;
      m_nfl    = (k == 2'd0) ? 2 : 3;
    end
  endtask

  task automatic step(input logic d, input logic [1:0] k, input logic a);
    dv  = d;
    km  = k;
    ack = a;
    @(posedge clk);
    model_update(d, k, a);
    #1;
  endtask

  task automatic do_reset(input int s);
    sel       = s;
    m_hold    = (s == 1);
    m_restart = (s != 2);
    rst       = 1'b0;
    dv        = 1'b0;
    ack       = 1'b0;
    m_active  = 1'b0;
    m_ov      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      if (dut_out() !== '0) begin
        errors++;
        $display("FAIL reset variant=%0d got=%h exp=0", s, dut_out());
      end
      checks++;
    end
  endtask

  task automatic test_basic_128();
    int n_rdy, n_fl, rdy_at;
    n_rdy = 0; n_fl = 0; rdy_at = -1;
    do_reset(0);
    for (int i = 0; i < 32; i++) begin
      step(i == 0, 2'd0, 1'b0);
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL basic_128 i=%0d got=%h exp=%h", i, dut_out(), model_out());
      end
      checks++;
      n_rdy += int'(rdy_v[0]);
      n_fl  += int'(fl_v[0]);
      if (rdy_v[0] && rdy_at < 0) rdy_at = i;
    end
    if (n_rdy !== 1 || rdy_at !== L128) begin
      errors++;
      $display("FAIL basic_128_rdy count=%0d at=%0d exp count=1 at=%0d", n_rdy, rdy_at, L128);
    end
    checks++;
    if (n_fl !== 2) begin
      errors++;
      $display("FAIL basic_128_fl count=%0d exp=2", n_fl);
    end
    checks++;
  endtask

  task automatic test_long_modes();
    int n_fl, rdy_at;
    for (int m = 2; m <= 3; m++) begin
      n_fl = 0; rdy_at = -1;
      do_reset(0);
      for (int i = 0; i < 39; i++) begin
        step(i == 0, 2'(m), 1'b0);
        if (dut_out() !== model_out()) begin
          errors++;
          $display("FAIL long_mode%0d i=%0d got=%h exp=%h", m, i, dut_out(), model_out());
        end
        checks++;
        n_fl += int'(fl_v[0]);
        if (rdy_v[0] && rdy_at < 0) rdy_at = i;
      end
      if (n_fl !== 3 || rdy_at !== L256) begin
        errors++;
        $display("FAIL long_mode%0d_timing fl=%0d rdy_at=%0d exp fl=3 rdy_at=%0d", m, n_fl, rdy_at, L256);
      end
      checks++;
    end
  endtask

  task automatic test_hold();
    int n_rdy, n_ov;
    logic d, a;
    n_rdy = 0; n_ov = 0;
    do_reset(1);
    for (int i = 0; i < 67; i++) begin
      d = (i == 0) || (i == 33) || (i == 61);
      a = (i == 33) || (i == 63);
      step(d, 2'd0, a);
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL hold i=%0d got=%h exp=%h", i, dut_out(), model_out());
      end
      checks++;
      if (i <= 33) n_rdy += int'(rdy_v[1]);
      n_ov += int'(ov_v[1]);
    end
    if (n_rdy !== 6 || n_ov !== 1) begin
      errors++;
      $display("FAIL hold_summary rdy_cycles=%0d overruns=%0d exp 6 and 1", n_rdy, n_ov);
    end
    checks++;
  endtask

  task automatic test_restart();
    int rdy_at;
    for (int s = 0; s <= 2; s += 2) begin
      rdy_at = -1;
      do_reset(s);
      for (int i = 0; i < 41; i++) begin
        step((i == 0) || (i == 10), 2'd0, 1'b0);
        if (dut_out() !== model_out()) begin
          errors++;
          $display("FAIL restart variant=%0d i=%0d got=%h exp=%h", s, i, dut_out(), model_out());
        end
        checks++;
        if (rdy_v[s] && rdy_at < 0) rdy_at = i;
      end
      if (rdy_at !== ((s == 0) ? 10 + L128 : L128)) begin
        errors++;
        $display("FAIL restart_rdy variant=%0d at=%0d exp=%0d", s, rdy_at,
                 (s == 0) ? 10 + L128 : L128);
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] k;
    do_reset(0);
    for (int i = 0; i < 16; i++) step(i == 0, 2'd0, 1'b0);
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL async_pre got=%h exp=%h", dut_out(), model_out());
    end
    checks++;
    #2;
    rst = 1'b0;
    m_active = 1'b0;
    m_ov     = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (dut_out() !== '0) begin
        errors++;
        $display("FAIL async_reset i=%0d got=%h exp=0", i, dut_out());
      end
      checks++;
      @(posedge clk);
      edge_n++;
      #1;
    end
    rst = 1'b1;
    k = 2'($urandom_range(0, 3));
    for (int i = 0; i < 50; i++) begin
      step(i == 10, k, 1'b0);
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL async_post i=%0d got=%h exp=%h", i, dut_out(), model_out());
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] k1, k2;
    int lat1, lat2, n_ov;
    n_ov = 0;
    for (int r = 0; r < 3; r++) begin
      k1 = 2'($urandom_range(0, 3));
      k2 = 2'($urandom_range(0, 3));
      lat1 = (k1 == 2'd0) ? L128 : L256;
      lat2 = (k2 == 2'd0) ? L128 : L256;
      do_reset(0);
      for (int i = 0; i < lat1 + lat2 + 4; i++) begin
        step((i == 0) || (i == lat1 + 1), (i == 0) ? k1 : k2, 1'b0);
        if (dut_out() !== model_out()) begin
          errors++;
          $display("FAIL back_to_back r=%0d i=%0d got=%h exp=%h", r, i, dut_out(), model_out());
        end
        checks++;
        n_ov += int'(ov_v[0]);
        if (i == lat1 + 1 + lat2) begin
          if (rdy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_rdy r=%0d got=%b exp=1", r, rdy_v[0]);
          end
          checks++;
        end
      end
    end
    if (n_ov !== 0) begin
      errors++;
      $display("FAIL back_to_back_overrun count=%0d exp=0", n_ov);
    end
    checks++;
  endtask

  task automatic test_random();
    logic d, a;
    logic [1:0] k;
    for (int s = 0; s < 3; s++) begin
      do_reset(s);
      for (int i = 0; i < 400; i++) begin
        d = ($urandom_range(0, 29) == 0);
        a = ($urandom_range(0, 3) == 0);
        k = 2'($urandom_range(0, 3));
        step(d, k, a);
        if (dut_out() !== model_out()) begin
          errors++;
          $display("FAIL random variant=%0d i=%0d got=%h exp=%h", s, i, dut_out(), model_out());
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_128();
    test_long_modes();
    test_hold();
    test_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
